// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared segment bit positions, glyph patterns and FSM state type
// Used by seg7_lookup and seg7_encode via import seg7_pkg::*.
package seg7_pkg;

  // Segment bit positions on the 8-bit bus (1 = lit)
  localparam int SEG_TOP = 0;
  localparam int SEG_TR  = 1;
  localparam int SEG_BR  = 2;
  localparam int SEG_BOT = 3;
  localparam int SEG_BL  = 4;
  localparam int SEG_TL  = 5;
  localparam int SEG_MID = 6;
  localparam int SEG_DP  = 7;

  // Glyph patterns on bits[6:0]
  localparam logic [6:0] PAT_0 = 7'h3F;
  localparam logic [6:0] PAT_1 = 7'h06;
  localparam logic [6:0] PAT_2 = 7'h5B;
  localparam logic [6:0] PAT_3 = 7'h4F;
  localparam logic [6:0] PAT_4 = 7'h66;
  localparam logic [6:0] PAT_5 = 7'h6D;
  localparam logic [6:0] PAT_6 = 7'h7D;
  localparam logic [6:0] PAT_7 = 7'h07;
  localparam logic [6:0] PAT_8 = 7'h7F;
  localparam logic [6:0] PAT_9 = 7'h6F;
  localparam logic [6:0] PAT_A = 7'h77;
  localparam logic [6:0] PAT_B = 7'h7C;
  localparam logic [6:0] PAT_C = 7'h39;
  localparam logic [6:0] PAT_D = 7'h5E;
  localparam logic [6:0] PAT_E = 7'h79;
  localparam logic [6:0] PAT_F = 7'h71;

  typedef enum logic {
    TRACK = 1'b0,
    OFFER = 1'b1
  } state_e;

endpackage

// File: rtl/seg7_if.sv
// rtl/seg7_if.sv - digit output stream with status flags
// master: encoder side (drives valid_out, num_out, dp_out, blank_out, err_out, err_count; reads ready_in)
// slave:  consumer side
interface seg7_if;
  logic       ready_in;
  logic       valid_out;
  logic [3:0] num_out;
  logic       dp_out;
  logic       blank_out;
  logic       err_out;
  logic [7:0] err_count;

  modport master (
    input  ready_in,
    output valid_out, num_out, dp_out, blank_out, err_out, err_count
  );

  modport slave (
    output ready_in,
    input  valid_out, num_out, dp_out, blank_out, err_out, err_count
  );
endinterface

// File: rtl/seg7_lookup.sv
// rtl/seg7_lookup.sv - combinational glyph decode, bits[6:0] -> value/legal/blank
// Ports: seg (in 7), value (out 4), legal (out 1, recognised glyph), blank (out 1, no segment lit).
// Hex glyphs A-F are recognised only when SEG7_HEX_EN is defined.
module seg7_lookup
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] value,
  output logic       legal,
  output logic       blank
);

  always_comb begin
    value = 4'h0;
    legal = 1'b1;
    blank = (seg == 7'h00);
    case (seg)
      PAT_0: value = 4'h0;
      PAT_1: value = 4'h1;
      PAT_2: value = 4'h2;
      PAT_3: value = 4'h3;
      PAT_4: value = 4'h4;
      PAT_5: value = 4'h5;
      PAT_6: value = 4'h6;
      PAT_7: value = 4'h7;
      PAT_8: value = 4'h8;
      PAT_9: value = 4'h9;
`ifdef SEG7_HEX_EN
      PAT_A: value = 4'hA;
      PAT_B: value = 4'hB;
      PAT_C: value = 4'hC;
      PAT_D: value = 4'hD;
      PAT_E: value = 4'hE;
      PAT_F: value = 4'hF;
`endif
      // blank also lands here; callers separate it via the blank flag
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_encode.sv
// rtl/seg7_encode.sv - debounce a 7-segment bus and recover the displayed digit
// Ports: clk, rst (sync, active-high), seg_in[7:0] (bit7 = dp), out_if (seg7_if.master).
// Parameter STABLE_CYCLES (2..15): identical samples needed to accept a pattern.
// Macro SEG7_HEX_EN: also decode glyphs A-F.
module seg7_encode
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] seg_in,
  seg7_if.master     out_if
);

  localparam logic [3:0] CNT_MAX = 4'(STABLE_CYCLES);
  localparam logic [3:0] CNT_ACC = 4'(STABLE_CYCLES - 1);

  state_e     state_q, state_d;
  logic [7:0] seg_q, seg_d;
  logic [7:0] last_acc_q, last_acc_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] num_q, num_d;
  logic       dp_q, dp_d;
  logic       blank_q, blank_d;
  logic       err_q, err_d;
  logic [7:0] err_cnt_q, err_cnt_d;
  logic       pend_valid_q, pend_valid_d;
  logic [3:0] pend_num_q, pend_num_d;
  logic       pend_dp_q, pend_dp_d;

  logic [3:0] lk_value;
  logic       lk_legal;
  logic       lk_blank;
  logic       accept;
  logic       acc_digit;
  logic       acc_err;

  seg7_lookup u_lookup (
    .seg   (seg_q[6:0]),
    .value (lk_value),
    .legal (lk_legal),
    .blank (lk_blank)
  );

  always_comb begin
    seg_d        = seg_in;
    state_d      = state_q;
    last_acc_d   = last_acc_q;
    num_d        = num_q;
    dp_d         = dp_q;
    blank_d      = blank_q;
    err_cnt_d    = err_cnt_q;
    pend_valid_d = pend_valid_q;
    pend_num_d   = pend_num_q;
    pend_dp_d    = pend_dp_q;

    if (seg_in != seg_q)        cnt_d = 4'd0;
    else if (cnt_q == CNT_MAX)  cnt_d = cnt_q;
    else                        cnt_d = cnt_q + 4'd1;

    // cnt passes CNT_ACC once per stable run, so a run accepts at most once;
    // the full byte is compared so a dp-only change counts as a new pattern
    accept    = (cnt_q == CNT_ACC) && (seg_q != last_acc_q);
    acc_digit = accept && lk_legal;
    acc_err   = accept && !lk_legal && !lk_blank;

    err_d = acc_err;
    if (acc_err && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;

    if (accept) begin
      last_acc_d = seg_q;
      blank_d    = lk_blank;
    end

    case (state_q)
      TRACK: begin
        if (acc_digit) begin
          num_d   = lk_value;
          dp_d    = seg_q[SEG_DP];
          state_d = OFFER;
        end
      end
      OFFER: begin
        if (out_if.ready_in) begin
          if (pend_valid_q) begin
            // pending digit goes out first; a simultaneous accept refills the slot
            num_d        = pend_num_q;
            dp_d         = pend_dp_q;
            pend_valid_d = acc_digit;
            if (acc_digit) begin
              pend_num_d = lk_value;
              pend_dp_d  = seg_q[SEG_DP];
            end
          end else if (acc_digit) begin
            num_d = lk_value;
            dp_d  = seg_q[SEG_DP];
          end else begin
            state_d = TRACK;
          end
        end else if (acc_digit) begin
          // single-entry slot: newer accepts overwrite an unsent pending digit
          pend_valid_d = 1'b1;
          pend_num_d   = lk_value;
          pend_dp_d    = seg_q[SEG_DP];
        end
      end
      default: state_d = TRACK;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= TRACK;
      seg_q        <= 8'h00;
      last_acc_q   <= 8'h00;
      cnt_q        <= 4'd0;
      num_q        <= 4'h0;
      dp_q         <= 1'b0;
      blank_q      <= 1'b1;
      err_q        <= 1'b0;
      err_cnt_q    <= 8'h00;
      pend_valid_q <= 1'b0;
      pend_num_q   <= 4'h0;
      pend_dp_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      seg_q        <= seg_d;
      last_acc_q   <= last_acc_d;
      cnt_q        <= cnt_d;
      num_q        <= num_d;
      dp_q         <= dp_d;
      blank_q      <= blank_d;
      err_q        <= err_d;
      err_cnt_q    <= err_cnt_d;
      pend_valid_q <= pend_valid_d;
      pend_num_q   <= pend_num_d;
      pend_dp_q    <= pend_dp_d;
    end
  end

  assign out_if.valid_out = (state_q == OFFER);
  assign out_if.num_out   = num_q;
  assign out_if.dp_out    = dp_q;
  assign out_if.blank_out = blank_q;
  assign out_if.err_out   = err_q;
  assign out_if.err_count = err_cnt_q;

endmodule

// File: tb/tb_seg7_encode.sv
// tb/tb_seg7_encode.sv - self-checking bench for seg7_encode (STABLE_CYCLES = 4)
module tb_seg7_encode;
  import seg7_pkg::*;

  typedef struct {
    logic [3:0] num;
    logic       dp;
  } digit_t;

  // kind: 0 = digit expected, 1 = blank, 2 = illegal
  typedef struct {
    logic [7:0] seg;
    int         kind;
    logic [3:0] num;
    logic       dp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] seg_in = 8'h00;

  seg7_if dig ();

  seg7_encode #(.STABLE_CYCLES(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .seg_in (seg_in),
    .out_if (dig)
  );

  always #5 clk = ~clk;

  digit_t sb[$];
  int total = 0;
  int bad = 0;
  int hs_count = 0;
  int err_seen = 0;
  int valid_cycles = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Scoreboard side: a handshake happens at the next rising edge whenever
  // valid_out and ready_in are both high at the falling edge.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (dig.err_out === 1'b1) err_seen++;
      if (dig.valid_out === 1'b1) valid_cycles++;
      if (dig.valid_out === 1'b1 && dig.ready_in === 1'b1) begin
        digit_t e;
        hs_count++;
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_digit: got num=%0h dp=%0b want no digit", dig.num_out, dig.dp_out);
        end else begin
          e = sb.pop_front();
          check("digit_num", dig.num_out, e.num);
          check("digit_dp", dig.dp_out, e.dp);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    seg_in       = 8'h00;
    dig.ready_in = 1'b1;
    tick(2);
    sb.delete();
    hs_count     = 0;
    err_seen     = 0;
    valid_cycles = 0;
    rst          = 1'b0;
  endtask

  vec_t vt[$];
  int   exp_err;
  int   first;

  initial begin
    dig.ready_in = 1'b1;

    // ---------------- reset state
    rst = 1'b1;
    tick(3);
    check("rst_valid", dig.valid_out, 0);
    check("rst_num", dig.num_out, 0);
    check("rst_dp", dig.dp_out, 0);
    check("rst_blank", dig.blank_out, 1);
    check("rst_err", dig.err_out, 0);
    check("rst_err_count", dig.err_count, 0);

    // ---------------- latency: 0x06 from reset, valid 5 edges after first sample
    do_reset();
    seg_in = 8'h06;
    sb.push_back('{4'h1, 1'b0});
    first = 0;
    for (int e = 1; e <= 9; e++) begin
      @(posedge clk);
      #1;
      if (dig.valid_out === 1'b1 && first == 0) first = e;
    end
    #1;
    check("latency_edges", first, 5);
    check("latency_handshakes", hs_count, 1);
    check("latency_sb_empty", sb.size(), 0);

    // ---------------- table-driven vectors, ready held high
    vt.push_back('{{1'b0, PAT_0}, 0, 4'h0, 1'b0});
    vt.push_back('{{1'b0, PAT_1}, 0, 4'h1, 1'b0});
    vt.push_back('{{1'b0, PAT_2}, 0, 4'h2, 1'b0});
    vt.push_back('{{1'b0, PAT_3}, 0, 4'h3, 1'b0});
    vt.push_back('{{1'b0, PAT_4}, 0, 4'h4, 1'b0});
    vt.push_back('{{1'b0, PAT_5}, 0, 4'h5, 1'b0});
    vt.push_back('{{1'b0, PAT_6}, 0, 4'h6, 1'b0});
    vt.push_back('{{1'b0, PAT_7}, 0, 4'h7, 1'b0});
    vt.push_back('{8'h7F, 0, 4'h8, 1'b0});
    vt.push_back('{8'hFF, 0, 4'h8, 1'b1});
    vt.push_back('{8'h6F, 0, 4'h9, 1'b0});
    vt.push_back('{8'hEF, 0, 4'h9, 1'b1});
    vt.push_back('{8'h00, 1, 4'h0, 1'b0});
    vt.push_back('{8'h80, 1, 4'h0, 1'b0});
    vt.push_back('{8'h01, 2, 4'h0, 1'b0});
    vt.push_back('{8'h3F, 0, 4'h0, 1'b0});
    vt.push_back('{8'h49, 2, 4'h0, 1'b0});
`ifdef SEG7_HEX_EN
    vt.push_back('{8'h77, 0, 4'hA, 1'b0});
    vt.push_back('{8'h7C, 0, 4'hB, 1'b0});
    vt.push_back('{8'hB9, 0, 4'hC, 1'b1});
    vt.push_back('{8'h5E, 0, 4'hD, 1'b0});
    vt.push_back('{8'h79, 0, 4'hE, 1'b0});
    vt.push_back('{8'h71, 0, 4'hF, 1'b0});
`else
    vt.push_back('{8'h77, 2, 4'h0, 1'b0});
    vt.push_back('{8'h7C, 2, 4'h0, 1'b0});
    vt.push_back('{8'hB9, 2, 4'h0, 1'b0});
    vt.push_back('{8'h5E, 2, 4'h0, 1'b0});
    vt.push_back('{8'h79, 2, 4'h0, 1'b0});
    vt.push_back('{8'h71, 2, 4'h0, 1'b0});
`endif
    vt.push_back('{8'h06, 0, 4'h1, 1'b0});

    do_reset();
    exp_err = 0;
    for (int i = 0; i < vt.size(); i++) begin
      seg_in = vt[i].seg;
      if (vt[i].kind == 0) sb.push_back('{vt[i].num, vt[i].dp});
      if (vt[i].kind == 2) exp_err++;
      tick(8);
      check("vec_err_count", dig.err_count, exp_err);
      check("vec_err_pulses", err_seen, exp_err);
      if (vt[i].kind != 2) check("vec_blank", dig.blank_out, (vt[i].kind == 1) ? 1 : 0);
    end
    check("vec_sb_empty", sb.size(), 0);

    // ---------------- toggling 0x5B/0x4F never settles; only the held 3 emerges
    do_reset();
    sb.push_back('{4'h3, 1'b0});
    for (int i = 0; i < 5; i++) begin
      seg_in = 8'h5B;
      tick(2);
      seg_in = 8'h4F;
      tick(2);
    end
    seg_in = 8'h5B;
    tick(2);
    seg_in = 8'h4F;
    tick(10);
    check("toggle_handshakes", hs_count, 1);
    check("toggle_sb_empty", sb.size(), 0);

    // ---------------- illegal pattern and error counter saturation
    do_reset();
    seg_in = 8'h01;
    tick(8);
    check("illegal_pulses", err_seen, 1);
    check("illegal_err_count", dig.err_count, 1);
    check("illegal_no_valid", valid_cycles, 0);
    for (int i = 0; i < 300; i++) begin
      seg_in = (i % 2 == 0) ? 8'h02 : 8'h01;
      tick(5);
    end
    tick(2);
    check("sat_err_count", dig.err_count, 255);
    check("sat_err_pulses", err_seen, 301);
    check("sat_no_valid", valid_cycles, 0);

    // ---------------- pending overwrite while stalled: 4 then 6, 5 lost
    do_reset();
    dig.ready_in = 1'b0;
    seg_in = 8'h66;
    tick(7);
    seg_in = 8'h6D;
    tick(7);
    seg_in = 8'h7D;
    tick(7);
    check("stall_valid", dig.valid_out, 1);
    check("stall_num", dig.num_out, 4'h4);
    sb.push_back('{4'h4, 1'b0});
    sb.push_back('{4'h6, 1'b0});
    dig.ready_in = 1'b1;
    tick(6);
    check("stall_handshakes", hs_count, 2);
    check("stall_sb_empty", sb.size(), 0);
    check("stall_valid_after", dig.valid_out, 0);

    // ---------------- reset during OFFER drops the digit
    do_reset();
    dig.ready_in = 1'b0;
    seg_in = 8'h06;
    tick(7);
    check("offer_valid_before_rst", dig.valid_out, 1);
    rst = 1'b1;
    seg_in = 8'h00;
    tick(1);
    check("offer_valid_after_rst", dig.valid_out, 0);
    rst = 1'b0;
    dig.ready_in = 1'b1;
    tick(8);
    check("offer_rst_handshakes", hs_count, 0);
    check("offer_rst_valid_idle", dig.valid_out, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety net in case a wait above never returns
  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

endmodule

// File: doc/seg7_encode.md
SEG7_ENCODE -- requirements
Module: seg7_encode

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4, range 2..15: consecutive identical samples required to accept a pattern.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port seg_in  input  8  segment bus, 1 = lit; bit0 top, bit1 top-right, bit2 bottom-right, bit3 bottom, bit4 bottom-left, bit5 top-left, bit6 centre, bit7 dp.
REQ-005 SHALL have port ready_in  input  1  downstream accepts the offered digit.
REQ-006 SHALL have port valid_out  output  1  digit offered.
REQ-007 SHALL have port num_out  output  4  recovered value 0x0..0xF.
REQ-008 SHALL have port dp_out  output  1  dp state captured with num_out.
REQ-009 SHALL have port blank_out  output  1  level: last accepted pattern had bits[6:0] = 0.
REQ-010 SHALL have port err_out  output  1  one-cycle pulse: illegal pattern accepted.
REQ-011 SHALL have port err_count  output  8  saturating count of err_out pulses.

Function
REQ-012 SHALL register seg_in into seg_q every cycle; run counter cnt clears when seg_in != seg_q, otherwise increments, saturating at STABLE_CYCLES.
REQ-013 SHALL accept a pattern when cnt == STABLE_CYCLES-1 and seg_q != last_acc; each stable run accepts at most once.
REQ-014 SHALL compare bits[7:0] for the change test, so a dp-only change is a new pattern.
REQ-015 SHALL decode bits[6:0]: 0x3F=0, 0x06=1, 0x5B=2, 0x4F=3, 0x66=4, 0x6D=5, 0x7D=6, 0x07=7, 0x7F=8, 0x6F=9; any other nonzero value is illegal.
REQ-016 SHALL, on accepting bits[6:0] = 0, set blank_out = 1 and emit no digit and no error.
REQ-017 SHALL, on accepting an illegal pattern, pulse err_out in the next cycle and increment err_count (saturating at 255); no digit emitted.
REQ-018 SHALL, on accepting a legal pattern, clear blank_out and raise valid_out in the next cycle: latency is STABLE_CYCLES+1 edges after the first edge that samples the new value.
REQ-019 SHALL implement FSM TRACK/OFFER: TRACK -> OFFER on legal accept; OFFER -> TRACK on ready_in = 1; valid_out = (state == OFFER).
REQ-020 SHALL hold num_out and dp_out stable while in OFFER.
REQ-021 SHALL keep tracking in OFFER: a legal accept there fills a one-entry pending slot, and later accepts overwrite it.
REQ-022 SHALL, on handshake with pending slot full, load the pending digit into num_out and stay in OFFER, keeping valid_out high.
REQ-023 SHALL give precedence to handshake then load when a handshake and an accept coincide: pending contents load first, and the new accept then becomes pending; with no pending, the new accept goes direct to num_out and valid_out stays 1.
REQ-024 SHALL update last_acc on every accept, including blank and illegal patterns.

Reset
REQ-025 SHALL, on rst, set state TRACK, valid_out 0, num_out 0, dp_out 0, blank_out 1, err_out 0, err_count 0, cnt 0, seg_q 0x00, last_acc 0x00 and pending empty.
REQ-026 SHALL, on rst mid-OFFER, drop the offered and pending digits with no handshake.

Configuration
REQ-027 SHALL, with macro SEG7_HEX_EN defined, also decode 0x77=A, 0x7C=b, 0x39=C, 0x5E=d, 0x79=E, 0x71=F.
REQ-028 SHALL, without SEG7_HEX_EN, treat those six patterns as illegal per REQ-017.

Structure
REQ-029 SHALL place the segment bit-position constants, the pattern constants for 0-9 and A-F, and the TRACK/OFFER enum in shared package seg7_pkg.
REQ-030 SHALL place the pattern-to-value decode in sub-module seg7_lookup (pure combinational: bits[6:0] -> value, legal, blank).

Verification
REQ-031 SHALL cover: seg_in 0x06 held 6 cycles from reset, ready_in 1 -> valid_out high 5 edges after first sample, num_out 1, dp_out 0, single handshake.
REQ-032 SHALL cover: seg_in toggling 0x5B/0x4F every 2 cycles, then 0x4F held -> exactly one digit 3, no digit 2.
REQ-033 SHALL cover: 0x7F then 0xFF (dp added), ready_in 1 -> two digits: 8 with dp_out 0, then 8 with dp_out 1.
REQ-034 SHALL cover: 0x01 held -> one err_out pulse, err_count 1, no valid_out; 300 distinct illegal accepts -> err_count 255.
REQ-035 SHALL cover: ready_in 0, accepts 0x66 then 0x6D then 0x7D, then ready_in 1 -> outputs 4 then 6; 5 is lost to overwrite.
REQ-036 SHALL cover: 0x77 held -> digit 0xA with SEG7_HEX_EN, err_out pulse without it; rst asserted during OFFER -> valid_out 0 next cycle.
